// File: rtl/bp_pkg.sv
// Shared types for the branch predict unit: 2-bit counter encoding, BTB entry
// layout and the saturating counter update.
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    // Wide enough for any legal PC_W up to 32; unused upper tag bits stay zero.
    localparam int TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic                 isjmp;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
    } btb_entry_t;

    localparam btb_entry_t ENTRY_RST = '{
        valid:  1'b0,
        isjmp:  1'b0,
        tag:    '0,
        target: '0,
        ctr:    CTR_WNT
    };

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_resolve.sv
// Execute-stage branch resolution: outcome, targets, misprediction and the
// redirect PC. Purely combinational.
module bp_resolve #(
    parameter int PC_W = 9
) (
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [31:0]     imm,
    input  logic            branch,
    input  logic            jmp_sel,
    input  logic            jalr_sel,
    input  logic            halt,
    input  logic [31:0]     alu_result,
    input  logic            pred_taken,
    input  logic [31:0]     pred_pc,
    output logic            taken,
    output logic [31:0]     pc_four,
    output logic [31:0]     pc_imm,
    output logic            mispredict,
    output logic [31:0]     redirect_pc
);

    logic [31:0] ex_pc_ext;

    // NOTE: every output gets a value before any conditional code, so no latch can be inferred.
    always_comb begin
        ex_pc_ext   = 32'(ex_pc);
        taken       = (branch & alu_result[0]) | jmp_sel;
        pc_imm      = jalr_sel ? alu_result : ex_pc_ext + imm;
        pc_four     = halt ? 32'd0 : ex_pc_ext + 32'd4;
        redirect_pc = taken ? pc_imm : pc_four;
        mispredict  = 1'b0;
        if (ex_valid && halt) begin
            // A halt always flushes and parks fetch at address zero.
            mispredict  = 1'b1;
            redirect_pc = 32'd0;
        end else if (ex_valid) begin
            mispredict = (taken != pred_taken) | (taken & (pc_imm != pred_pc));
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup, EX-stage
// resolution and training. Define BP_STATS_EN to add branch/mispredict counters.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = PC_W - $clog2(ENTRIES) - 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] F_PC,
    output logic            Pred_Taken,
    output logic [31:0]     Pred_PC,
    input  logic            Ex_Valid,
    input  logic [PC_W-1:0] Ex_PC,
    input  logic [31:0]     Imm,
    input  logic            Branch,
    input  logic            JmpSel,
    input  logic            JalrSel,
    input  logic            flag_halt,
    input  logic [31:0]     AluResult,
    input  logic            Ex_PredTaken,
    input  logic [31:0]     Ex_PredPC,
    output logic [31:0]     PC_Four,
    output logic [31:0]     PC_Imm,
    output logic            Mispredict,
    output logic [31:0]     Redirect_PC
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     Stat_Branches,
    output logic [31:0]     Stat_Mispred
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t       table_q [ENTRIES];
    btb_entry_t       table_d [ENTRIES];
    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    btb_entry_t       f_ent, e_ent;
    logic             f_hit, e_hit, ex_taken, train;

    assign f_idx = F_PC[IDX_W+1:2];
    assign f_tag = F_PC[PC_W-1:IDX_W+2];
    assign e_idx = Ex_PC[IDX_W+1:2];
    assign e_tag = Ex_PC[PC_W-1:IDX_W+2];

    bp_resolve #(.PC_W(PC_W)) u_resolve (
        .ex_valid    (Ex_Valid),
        .ex_pc       (Ex_PC),
        .imm         (Imm),
        .branch      (Branch),
        .jmp_sel     (JmpSel),
        .jalr_sel    (JalrSel),
        .halt        (flag_halt),
        .alu_result  (AluResult),
        .pred_taken  (Ex_PredTaken),
        .pred_pc     (Ex_PredPC),
        .taken       (ex_taken),
        .pc_four     (PC_Four),
        .pc_imm      (PC_Imm),
        .mispredict  (Mispredict),
        .redirect_pc (Redirect_PC)
    );

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        f_ent      = table_q[f_idx];
        f_hit      = f_ent.valid & (f_ent.tag == TAG_MAX_W'(f_tag));
        Pred_Taken = f_hit & (f_ent.isjmp | (f_ent.ctr inside {CTR_WT, CTR_ST}));
        Pred_PC    = Pred_Taken ? f_ent.target : 32'(F_PC) + 32'd4;
    end

    always_comb begin
        e_ent   = table_q[e_idx];
        e_hit   = e_ent.valid & (e_ent.tag == TAG_MAX_W'(e_tag));
        train   = Ex_Valid & ~flag_halt & (Branch | JmpSel);
        table_d = table_q;
        if (train) begin
            if (e_hit) begin
                table_d[e_idx].ctr   = sat_update(e_ent.ctr, ex_taken);
                table_d[e_idx].isjmp = JmpSel;
                if (ex_taken) begin
                    table_d[e_idx].target = PC_Imm;
                end
            end else if (ex_taken) begin
                table_d[e_idx] = '{
                    valid:  1'b1,
                    isjmp:  JmpSel,
                    tag:    TAG_MAX_W'(e_tag),
                    target: PC_Imm,
                    ctr:    CTR_WT
                };
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the whole table is reset; only valid and ctr matter, but a uniform reset keeps each flop simple.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= ENTRY_RST;
            end
        end else begin
            table_q <= table_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q + (train ? 32'd1 : 32'd0);
        stat_mp_d = stat_mp_q + ((Mispredict & ~flag_halt) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign Stat_Branches = stat_br_q;
    assign Stat_Mispred  = stat_mp_q;
`endif

endmodule
